a10_xcvr_reconfig_responder: RTL and testbench
==============================================

A10_XCVR_RECONFIG_RESPONDER -- requirements
Module: a10_xcvr_reconfig_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PLL_TYPE, "fPLL", emulated PLL ("fPLL" | "CMUPLL" | "ATXPLL"); selects the cal-enable bit: ATXPLL=bit0, fPLL=bit1, CMUPLL=bit5.
  WAIT_CYCLES, 2, waitrequest stall cycles per access (0 allowed).
  INIT_CAL_CYCLES, 64, power-up calibration duration in clk cycles (>=1).
  CAL_CYCLES, 32, user-triggered recalibration duration in clk cycles (>=1).
  LOCK_CYCLES, 16, cycles from powerdown/cal release to lock (>=1).
  CAL_REG_INIT, 32'h0000_0000, reset value of the calibration register (address 0x100).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock.
  reset  input  1  asynchronous, active-low reset (0 = reset).
  reconfig_address  input  10  Avalon-MM word address.
  reconfig_write  input  1  write request.
  reconfig_writedata  input  32  write data.
  reconfig_read  input  1  read request.
  reconfig_readdata  output  32  read data.
  reconfig_waitrequest  output  1  access stall.
  pll_powerdown  input  1  PLL powerdown request from the initiator.
  pll_cal_busy  output  1  calibration in progress.
  pll_locked  output  1  emulated lock.
  access_error  output  1  sticky protocol-violation flag.

Function
REQ-003 Registers: 0x000 = arbitration register (write-only effect; reads return the last written value). 0x100 = calibration register (32-bit read/write). All other addresses SHALL read 0 and ignore writes.
REQ-004 Access timing: an access is pending while read or write is high. A wait counter SHALL hold waitrequest=1 for WAIT_CYCLES cycles, then drive waitrequest=0 for exactly one completion cycle. The counter then reloads to WAIT_CYCLES. With WAIT_CYCLES=0, every pending cycle SHALL complete.
REQ-005 waitrequest SHALL be 0 when no access is pending.
REQ-006 readdata SHALL be valid (combinational register mux) only in a read completion cycle, and 0 otherwise.
REQ-007 If read and write are both high, the access SHALL be treated as a write, and access_error SHALL be set.
REQ-008 If address or data changes while an access is stalled, access_error SHALL be set. The completion SHALL use the values present at the completion cycle.
REQ-009 The FSM states SHALL be INIT_CAL, READY, USER and CAL.
REQ-010 INIT_CAL is entered on reset. It SHALL last INIT_CAL_CYCLES cycles and then go to READY.
REQ-011 In READY, a completed write of 0x2 to 0x000 SHALL go to USER.
REQ-012 In USER, a completed write of 0x1 to 0x000 SHALL go to CAL if the PLL_TYPE enable bit of 0x100 is 1, else to READY.
REQ-013 CAL SHALL last CAL_CYCLES cycles. On exit, the PLL_TYPE enable bit of 0x100 SHALL be cleared (other bits kept) and the FSM SHALL go to READY.
REQ-014 Writes to 0x000 with other values, or arriving in other states, SHALL be stored but SHALL cause no transition.
REQ-015 Access to 0x100 outside USER: a write SHALL be ignored, a read SHALL return 0, and access_error SHALL be set.
REQ-016 Accesses SHALL still complete normally during INIT_CAL and CAL; no stall beyond WAIT_CYCLES.
REQ-017 pll_cal_busy SHALL be registered and equal 1 exactly in INIT_CAL and CAL. It SHALL rise on the clock edge that completes the 0x1 write.
REQ-018 pll_locked SHALL be 0 while pll_powerdown=1 or pll_cal_busy=1.
REQ-019 A lock counter SHALL restart whenever either condition in REQ-018 is true. pll_locked SHALL rise LOCK_CYCLES cycles after both are low.
REQ-020 pll_powerdown SHALL NOT affect the FSM, registers or access handling.
REQ-021 access_error SHALL be sticky until reset.

Reset
REQ-022 While reset=0, asynchronously: FSM = INIT_CAL, pll_cal_busy=1, pll_locked=0, access_error=0, waitrequest=0, readdata=0, 0x000=0, 0x100=CAL_REG_INIT, and counters reloaded.
REQ-023 Reset asserted mid-access or mid-CAL SHALL abort the activity. No register update SHALL occur for an access not completed before reset.
REQ-024 The initial (simulation) state SHALL equal the reset state.

Verification
REQ-025 Release reset with defaults -> pll_cal_busy=1 for 64 cycles then 0; pll_locked=1 after 16 further cycles.
REQ-026 Run the full fPLL sequence: write 0x2 to 0x000, read 0x100 (returns 0), write 0x2 to 0x100, write 0x1 to 0x000. Required response: each access sees 2 stall cycles; cal_busy is high for 32 cycles; 0x100 then reads 0 after writing 0x2 back to 0x000; access_error=0.
REQ-027 Write 0x1 to 0x000 in USER with 0x100=0x20 (PLL_TYPE="fPLL") -> no calibration; FSM returns to READY; cal_busy stays 0.
REQ-028 Read 0x100 in READY -> readdata=0 and access_error=1.
REQ-029 Hold pll_powerdown=1 for 10 cycles while locked -> pll_locked=0 immediately registered; pll_locked=1 again 16 cycles after release.
REQ-030 With WAIT_CYCLES=0, apply back-to-back reads and a simultaneous read+write, and assert reset during CAL -> one-cycle completions; write wins and access_error=1; cal_busy stays 1 and the FSM restarts in INIT_CAL.

Source files
------------

// File: rtl/a10_xcvr_reconfig_responder.sv
// Purpose: behavioural stand-in for an Arria 10 PLL reconfiguration port.
//   It models the arbitration register (0x000), the calibration register (0x100),
//   the calibration FSM, and emulated cal_busy/lock.
// Latency: an access completes WAIT_CYCLES cycles after it is first presented;
//   read data is combinational in the completion cycle.
// Backpressure: waitrequest is held high for WAIT_CYCLES cycles of each pending
//   access, then drops for exactly one completion cycle.
// Ports: clk, reset (async, active-low); reconfig_* Avalon-MM slave;
//   pll_powerdown in; pll_cal_busy, pll_locked, access_error (sticky) out.
module a10_xcvr_reconfig_responder #(
  parameter string       PLL_TYPE        = "fPLL",
  parameter int          WAIT_CYCLES     = 2,
  parameter int          INIT_CAL_CYCLES = 64,
  parameter int          CAL_CYCLES      = 32,
  parameter int          LOCK_CYCLES     = 16,
  parameter logic [31:0] CAL_REG_INIT    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  reconfig_address,
  input  logic        reconfig_write,
  input  logic [31:0] reconfig_writedata,
  input  logic        reconfig_read,
  output logic [31:0] reconfig_readdata,
  output logic        reconfig_waitrequest,
  input  logic        pll_powerdown,
  output logic        pll_cal_busy,
  output logic        pll_locked,
  output logic        access_error
);

  // Calibration-enable bit inside 0x100 for the emulated PLL flavour.
  localparam int CAL_BIT = (PLL_TYPE == "ATXPLL") ? 0 : ((PLL_TYPE == "CMUPLL") ? 5 : 1);
  localparam int WW      = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int CAL_MAX = (INIT_CAL_CYCLES > CAL_CYCLES) ? INIT_CAL_CYCLES : CAL_CYCLES;
  localparam int CW      = (CAL_MAX < 2) ? 1 : $clog2(CAL_MAX);
  localparam int LW      = $clog2(LOCK_CYCLES + 1);

  localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_CYCLES);
  localparam logic [CW-1:0] INIT_LOAD = CW'(INIT_CAL_CYCLES - 1);
  localparam logic [CW-1:0] CAL_LOAD  = CW'(CAL_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES);

  typedef enum logic [1:0] {INIT_CAL, READY, USER, CAL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cal_cnt_q, cal_cnt_d;
  logic          cal_clr;
  logic [WW-1:0] wait_cnt;
  logic          stalled_q;
  logic [9:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   arb_q, cal_q;
  logic          busy_q, err_q, lock_q;
  logic [LW-1:0] lock_cnt;
  logic [31:0]   rdata;

  logic pending, stall, complete, addr_arb, addr_cal, arb_wr, changed, err_set;

  assign pending  = reconfig_read | reconfig_write;
  assign stall    = pending && (wait_cnt != '0);
  assign complete = pending && (wait_cnt == '0);
  assign addr_arb = (reconfig_address == 10'h000);
  assign addr_cal = (reconfig_address == 10'h100);
  // A simultaneous read+write is handled as a write.
  assign arb_wr   = complete && reconfig_write && addr_arb;

  // Any address/data movement between two cycles of the same stalled access.
  assign changed = stalled_q && pending &&
                   ((reconfig_address != addr_q) ||
                    (reconfig_write && (reconfig_writedata != wdata_q)));
  assign err_set = (pending && reconfig_read && reconfig_write) || changed ||
                   (complete && addr_cal && (state_q != USER));

  // Wait counter: reloads on completion and whenever the bus is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= WAIT_LOAD;
      stalled_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      if (complete || !pending) wait_cnt <= WAIT_LOAD;
      else                      wait_cnt <= wait_cnt - 1'b1;
      stalled_q <= stall;
      addr_q    <= reconfig_address;
      wdata_q   <= reconfig_writedata;
    end
  end

  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    cal_clr   = 1'b0;
    case (state_q)
      INIT_CAL: begin
        if (cal_cnt_q == '0) state_d = READY;
        else                 cal_cnt_d = cal_cnt_q - 1'b1;
      end
      READY: begin
        if (arb_wr && (reconfig_writedata == 32'd2)) state_d = USER;
      end
      USER: begin
        if (arb_wr && (reconfig_writedata == 32'd1)) begin
          if (cal_q[CAL_BIT]) begin
            state_d   = CAL;
            cal_cnt_d = CAL_LOAD;
          end else begin
            state_d = READY;
          end
        end
      end
      CAL: begin
        if (cal_cnt_q == '0) begin
          state_d = READY;
          cal_clr = 1'b1;
        end else begin
          cal_cnt_d = cal_cnt_q - 1'b1;
        end
      end
      default: state_d = INIT_CAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT_CAL;
      cal_cnt_q <= INIT_LOAD;
      busy_q    <= 1'b1;
      arb_q     <= '0;
      cal_q     <= CAL_REG_INIT;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cal_cnt_q <= cal_cnt_d;
      // Registered from the next state so busy rises on the completing edge.
      busy_q    <= (state_d == INIT_CAL) || (state_d == CAL);
      if (arb_wr) arb_q <= reconfig_writedata;
      if (cal_clr)
        cal_q[CAL_BIT] <= 1'b0;
      else if (complete && reconfig_write && addr_cal && (state_q == USER))
        cal_q <= reconfig_writedata;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Lock emulation: counter restarts while powered down or calibrating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_cnt <= LOCK_LOAD;
      lock_q   <= 1'b0;
    end else if (pll_powerdown || busy_q) begin
      lock_cnt <= LOCK_LOAD;
      lock_q   <= 1'b0;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
      if (lock_cnt == LW'(1)) lock_q <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (complete && reconfig_read && !reconfig_write) begin
      if (addr_arb)                         rdata = arb_q;
      else if (addr_cal && state_q == USER) rdata = cal_q;
    end
  end

  // Bus outputs are forced quiet while reset is held, even with a request present.
  assign reconfig_readdata    = reset ? rdata : 32'h0;
  assign reconfig_waitrequest = reset & stall;
  assign pll_cal_busy         = busy_q;
  // Gating keeps lock low in the same cycle powerdown or busy appears.
  assign pll_locked           = lock_q & ~pll_powerdown & ~busy_q;
  assign access_error         = err_q;

endmodule

// File: tb/tb_a10_xcvr_reconfig_responder.sv
module tb_a10_xcvr_reconfig_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic [9:0]  addr;
  logic        rd, wr, pd;
  logic [31:0] wdat;
  logic [31:0] rdata_a, rdata_b, o_rdata;
  logic        wq_a, wq_b, busy_a, busy_b, lock_a, lock_b, err_a, err_b;
  logic        o_wq, o_busy, o_lock, o_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  a10_xcvr_reconfig_responder u_a (
    .clk(clk), .reset(rst_a), .reconfig_address(addr), .reconfig_write(wr),
    .reconfig_writedata(wdat), .reconfig_read(rd), .reconfig_readdata(rdata_a),
    .reconfig_waitrequest(wq_a), .pll_powerdown(pd), .pll_cal_busy(busy_a),
    .pll_locked(lock_a), .access_error(err_a));

  a10_xcvr_reconfig_responder #(
    .PLL_TYPE("ATXPLL"), .WAIT_CYCLES(0), .INIT_CAL_CYCLES(8), .CAL_CYCLES(6),
    .LOCK_CYCLES(4), .CAL_REG_INIT(32'h0000_0001)
  ) u_b (
    .clk(clk), .reset(rst_b), .reconfig_address(addr), .reconfig_write(wr),
    .reconfig_writedata(wdat), .reconfig_read(rd), .reconfig_readdata(rdata_b),
    .reconfig_waitrequest(wq_b), .pll_powerdown(pd), .pll_cal_busy(busy_b),
    .pll_locked(lock_b), .access_error(err_b));

  // Both instances share the bus; the one not under test is held in reset.
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_wq    = sel ? wq_b    : wq_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_lock  = sel ? lock_b  : lock_a;
  assign o_err   = sel ? err_b   : err_a;

  // Reference model: register contents, mode, and the edge at which CAL began.
  localparam int S_INIT = 0, S_READY = 1, S_USER = 2, S_CAL = 3;
  logic [31:0] m_arb, m_cal;
  int          m_state, m_cal_start, m_wait, m_calc, m_bit;
  logic        m_err;

  function automatic void m_reset(input logic [31:0] cal_init);
    m_arb   = 32'h0;
    m_cal   = cal_init;
    m_state = S_INIT;
    m_err   = 1'b0;
  endfunction

  // State seen by an access completing at edge e: CAL covers edges start+1..start+CALC.
  function automatic void m_refresh(input int e);
    if (m_state == S_CAL && (e - 1) >= (m_cal_start + m_calc)) begin
      m_state     = S_READY;
      m_cal[m_bit] = 1'b0;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic access(input string tag, input logic [9:0] a, input logic r,
                        input logic w, input logic [31:0] d);
    int          stalls;
    int          m;
    logic [31:0] got;
    logic [31:0] expd;
    bit          done;
    stalls = 0;
    done   = 1'b0;
    got    = 'x;
    addr = a; rd = r; wr = w; wdat = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (o_wq) stalls++;
      else begin
        done = 1'b1;
        got  = o_rdata;
      end
      @(posedge clk);
    end
    #1;
    rd = 1'b0; wr = 1'b0;
    m = cyc;
    m_refresh(m);
    expd = 32'h0;
    if (r && w) m_err = 1'b1;
    if (a == 10'h100 && m_state != S_USER) m_err = 1'b1;
    if (w) begin
      if (a == 10'h000) begin
        m_arb = d;
        if (m_state == S_READY && d == 32'd2) m_state = S_USER;
        else if (m_state == S_USER && d == 32'd1) begin
          if (m_cal[m_bit]) begin
            m_state     = S_CAL;
            m_cal_start = m;
          end else begin
            m_state = S_READY;
          end
        end
      end else if (a == 10'h100 && m_state == S_USER) begin
        m_cal = d;
      end
    end else if (a == 10'h000) begin
      expd = m_arb;
    end else if (a == 10'h100 && m_state == S_USER) begin
      expd = m_cal;
    end
    m_refresh(m + 1);
    check({tag, ".stalls"}, stalls, m_wait);
    check({tag, ".rdata"}, got, expd);
    check({tag, ".err"}, o_err, m_err);
    check({tag, ".busy"}, o_busy, (m_state == S_CAL || m_state == S_INIT));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_busy && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic count_lock(output int n);
    n = 0;
    while (!o_lock && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; pd = 1'b0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdat = '0;
    m_wait = 2; m_calc = 32; m_bit = 1; m_cal_start = 0;
    m_reset(32'h0);

    // Reset state, including a read held during reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", o_busy, 1);
    check("rst.lock", o_lock, 0);
    check("rst.err", o_err, 0);
    rd = 1'b1; #1;
    check("rst.wq", o_wq, 0);
    check("rst.rdata", o_rdata, 0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;

    // Power-up calibration then lock.
    count_busy(n);  check("init.len", n, 64);
    m_state = S_READY;
    count_lock(n);  check("init.lock", n, 16);
    check("idle.wq", o_wq, 0);

    // Full fPLL calibration sequence.
    access("arb2", 10'h000, 0, 1, 32'h2);
    access("rd_cal0", 10'h100, 1, 0, 0);
    access("wr_cal2", 10'h100, 0, 1, 32'h2);
    access("arb1_cal", 10'h000, 0, 1, 32'h1);
    count_busy(n);  check("cal.len", n, 32);
    access("arb2_again", 10'h000, 0, 1, 32'h2);
    access("rd_cal_clr", 10'h100, 1, 0, 0);

    // Enable bit for a different PLL type: no calibration.
    access("wr_cal20", 10'h100, 0, 1, 32'h20);
    access("arb1_nocal", 10'h000, 0, 1, 32'h1);
    @(posedge clk); #1;
    check("nocal.busy", o_busy, 0);
    access("rd_cal_ready", 10'h100, 1, 0, 0);
    access("rd_arb", 10'h000, 1, 0, 0);

    // Powerdown drops lock immediately; relock after release.
    count_lock(n);
    check("pre_pd.lock", o_lock, 1);
    pd = 1'b1; #1;
    check("pd.lock_now", o_lock, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("pd.lock%0d", i), o_lock, 0);
    end
    pd = 1'b0;
    count_lock(n);  check("pd.relock", n, 16);

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      logic [9:0]  a;
      logic        r, w;
      logic [31:0] d;
      int          k, j;
      k = $urandom_range(0, 3);
      a = (k == 0) ? 10'h000 : ((k == 3) ? 10'($urandom) : 10'h100);
      k = $urandom_range(0, 7);
      r = (k <= 3);
      w = (k >= 3);
      j = $urandom_range(0, 2);
      if (a == 10'h000) d = (j == 0) ? 32'h1 : ((j == 1) ? 32'h2 : $urandom);
      else              d = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      access($sformatf("rnd%0d", i), a, r, w, d);
    end

    // Reset in the middle of a stalled write aborts it.
    addr = 10'h000; wr = 1'b1; wdat = 32'h2;
    @(negedge clk);
    check("mid.stall", o_wq, 1);
    rst_a = 1'b0; #1;
    check("mid.wq", o_wq, 0);
    check("mid.rdata", o_rdata, 0);
    check("mid.busy", o_busy, 1);
    check("mid.lock", o_lock, 0);
    check("mid.err", o_err, 0);
    wr = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    m_reset(32'h0);
    count_busy(n);  check("reinit.len", n, 64);
    m_state = S_READY;
    access("aborted", 10'h000, 1, 0, 0);

    // Data change during a stall: flagged, completion uses final data.
    addr = 10'h000; wr = 1'b1; wdat = 32'h7;
    @(posedge clk); #1;
    wdat = 32'h9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!o_wq) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr = 1'b0;
    m_arb = 32'h9;
    m_err = 1'b1;
    access("chg_rd", 10'h000, 1, 0, 0);

    // Second instance: zero wait states, ATXPLL enable bit.
    rst_a = 1'b0; sel = 1'b1;
    m_wait = 0; m_calc = 6; m_bit = 0;
    m_reset(32'h1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    count_busy(n);  check("b.init", n, 8);
    m_state = S_READY;
    count_lock(n);  check("b.lock", n, 4);
    access("b.rd0", 10'h000, 1, 0, 0);
    access("b.rd1", 10'h001, 1, 0, 0);
    access("b.rd2", 10'h3ff, 1, 0, 0);
    access("b.rd3", 10'h000, 1, 0, 0);
    access("b.rw", 10'h000, 1, 1, 32'h5);
    access("b.rd_rw", 10'h000, 1, 0, 0);
    access("b.arb2", 10'h000, 0, 1, 32'h2);
    access("b.rd_cal", 10'h100, 1, 0, 0);
    access("b.arb1", 10'h000, 0, 1, 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    addr = 10'h000; rd = 1'b1;
    rst_b = 1'b0; #1;
    check("b.rst.busy", o_busy, 1);
    check("b.rst.lock", o_lock, 0);
    check("b.rst.err", o_err, 0);
    check("b.rst.rdata", o_rdata, 0);
    check("b.rst.wq", o_wq, 0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    m_reset(32'h1);
    count_busy(n);  check("b.reinit", n, 8);
    m_state = S_READY;
    access("b.arb2b", 10'h000, 0, 1, 32'h2);
    access("b.rd_cal_rst", 10'h100, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
